// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC register, single-outstanding imem
// request/response handshake, one-entry holding buffer and IF/ID register.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   PCWrite           1 = PC may advance / issue a fetch, 0 = freeze PC
//   IF_ID_Write       1 = IF/ID may update, 0 = hold IF/ID
//   branch_taken      ID-stage redirect request (honoured only with PCWrite)
//   branch_target     redirect address
//   imem_req          fetch request strobe (combinational, same-cycle bypass)
//   imem_addr         fetch address, valid with imem_req
//   imem_valid        response strobe, >= 1 cycle after imem_req
//   imem_rdata        instruction word, valid with imem_valid
//   IF_ID_PC          PC of the instruction in IF/ID
//   IF_ID_Instr       instruction in IF/ID
//   IF_ID_Valid       IF/ID holds a real instruction
module if_fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           PC_INC     = 4,
    parameter logic [31:0]           NOP_INSTR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PCWrite,
    input  logic                  IF_ID_Write,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_valid,
    input  logic [31:0]           imem_rdata,
    output logic [ADDR_WIDTH-1:0] IF_ID_PC,
    output logic [31:0]           IF_ID_Instr,
    output logic                  IF_ID_Valid
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [ADDR_WIDTH-1:0]   req_pc;
    logic [ADDR_WIDTH-1:0]   hold_pc;
    logic [31:0]             hold_instr;
    logic                    kill;

    logic                    br;
    logic [ADDR_WIDTH-1:0]   fetch_addr;
    logic                    deliver;
    logic [ADDR_WIDTH-1:0]   deliver_pc;
    logic [31:0]             deliver_instr;

    // A branch seen while PC is frozen is re-raised later by the stalled ID stage.
    assign br         = branch_taken & PCWrite;
    assign fetch_addr = br ? branch_target : pc;

    // Request is combinational so a same-cycle branch redirects without a wasted fetch.
    assign imem_req  = rst_n & (state == S_REQ) & PCWrite;
    assign imem_addr = fetch_addr;

    // Select the instruction (if any) handed to IF/ID this cycle.
    always_comb begin
        deliver       = 1'b0;
        deliver_pc    = hold_pc;
        deliver_instr = hold_instr;
        case (state)
            S_WAIT: begin
                if (imem_valid && !kill && !br && IF_ID_Write) begin
                    deliver       = 1'b1;
                    deliver_pc    = req_pc;
                    deliver_instr = imem_rdata;
                end
            end
            S_FULL: begin
                if (!br && IF_ID_Write) begin
                    deliver = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Fetch state machine, PC/buffer registers and IF/ID register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            req_pc      <= '0;
            hold_pc     <= '0;
            hold_instr  <= '0;
            kill        <= 1'b0;
            IF_ID_PC    <= '0;
            IF_ID_Instr <= NOP_INSTR;
            IF_ID_Valid <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (PCWrite) begin
                        req_pc <= fetch_addr;
                        pc     <= fetch_addr + ADDR_WIDTH'(PC_INC);
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (br) begin
                        pc <= branch_target;
                    end
                    if (imem_valid) begin
                        // Response consumed: any pending kill is spent.
                        kill <= 1'b0;
                        if (!kill && !br && !IF_ID_Write) begin
                            hold_pc    <= req_pc;
                            hold_instr <= imem_rdata;
                            state      <= S_FULL;
                        end else begin
                            state <= S_REQ;
                        end
                    end else if (br) begin
                        // Response still in flight belongs to the wrong path.
                        kill <= 1'b1;
                    end
                end
                S_FULL: begin
                    if (br) begin
                        pc    <= branch_target;
                        state <= S_REQ;
                    end else if (IF_ID_Write) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase

            // Flush beats stall; otherwise load the delivered word or a bubble.
            if (br) begin
                IF_ID_Instr <= NOP_INSTR;
                IF_ID_Valid <= 1'b0;
            end else if (IF_ID_Write) begin
                if (deliver) begin
                    IF_ID_PC    <= deliver_pc;
                    IF_ID_Instr <= deliver_instr;
                    IF_ID_Valid <= 1'b1;
                end else begin
                    IF_ID_Instr <= NOP_INSTR;
                    IF_ID_Valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_Instr;
    logic        IF_ID_Valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PCWrite       (PCWrite),
        .IF_ID_Write   (IF_ID_Write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .IF_ID_PC      (IF_ID_PC),
        .IF_ID_Instr   (IF_ID_Instr),
        .IF_ID_Valid   (IF_ID_Valid)
    );

    // Reference model: one optional outstanding fetch, one optional parked word.
    bit          m_out;
    bit          m_kill;
    logic [31:0] m_out_pc;
    bit          m_buf;
    logic [31:0] m_buf_pc;
    logic [31:0] m_buf_instr;
    logic [31:0] m_pc;
    logic [31:0] m_if_pc;
    logic [31:0] m_if_instr;
    bit          m_if_v;

    // Memory responder state for the random phase.
    bit          mem_busy;
    int          mem_due;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_out = 0; m_kill = 0; m_out_pc = '0;
        m_buf = 0; m_buf_pc = '0; m_buf_instr = '0;
        m_pc = 32'h0;
        m_if_pc = '0; m_if_instr = NOP; m_if_v = 0;
    endtask

    task automatic compare_outputs();
        bit          exp_req;
        logic [31:0] exp_addr;
        exp_req  = rst_n && !m_out && !m_buf && PCWrite;
        exp_addr = (branch_taken && PCWrite) ? branch_target : m_pc;
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check("imem_addr", imem_addr, exp_addr);
        check("IF_ID_PC", IF_ID_PC, m_if_pc);
        check("IF_ID_Instr", IF_ID_Instr, m_if_instr);
        check("IF_ID_Valid", 32'(IF_ID_Valid), 32'(m_if_v));
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit          br;
        bit          got;
        logic [31:0] got_pc;
        logic [31:0] got_instr;
        logic [31:0] a;
        if (!rst_n) return;
        br  = branch_taken && PCWrite;
        got = 0; got_pc = '0; got_instr = '0;
        if (m_out) begin
            if (br) m_pc = branch_target;
            if (imem_valid) begin
                m_out = 0;
                if (m_kill)           m_kill = 0;
                else if (br)          ;
                else if (IF_ID_Write) begin got = 1; got_pc = m_out_pc; got_instr = imem_rdata; end
                else begin m_buf = 1; m_buf_pc = m_out_pc; m_buf_instr = imem_rdata; end
            end else if (br) begin
                m_kill = 1;
            end
        end else if (m_buf) begin
            if (br) begin
                m_buf = 0;
                m_pc  = branch_target;
            end else if (IF_ID_Write) begin
                m_buf = 0;
                got = 1; got_pc = m_buf_pc; got_instr = m_buf_instr;
            end
        end else if (PCWrite) begin
            a        = br ? branch_target : m_pc;
            m_out    = 1;
            m_out_pc = a;
            m_pc     = a + 32'd4;
        end
        if (br) begin
            m_if_instr = NOP; m_if_v = 0;
        end else if (IF_ID_Write) begin
            if (got) begin
                m_if_pc = got_pc; m_if_instr = got_instr; m_if_v = 1;
            end else begin
                m_if_instr = NOP; m_if_v = 0;
            end
        end
    endtask

    task automatic cycle(input bit pw, input bit iw, input bit bt, input logic [31:0] tgt,
                         input bit v, input logic [31:0] rd);
        @(negedge clk);
        PCWrite       = pw;
        IF_ID_Write   = iw;
        branch_taken  = bt;
        branch_target = tgt;
        imem_valid    = v;
        imem_rdata    = rd;
        #1;
        compare_outputs();
        model_step();
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] tgt;
        bit          v;
        rst_n = 0; PCWrite = 1; IF_ID_Write = 1; branch_taken = 0;
        branch_target = '0; imem_valid = 0; imem_rdata = '0;
        mem_busy = 0; mem_due = 0;
        model_reset();

        // Reset values, request suppressed while reset is held.
        repeat (2) @(negedge clk);
        #1;
        check("rst imem_req", 32'(imem_req), 32'd0);
        check("rst IF_ID_Valid", 32'(IF_ID_Valid), 32'd0);
        check("rst IF_ID_PC", IF_ID_PC, 32'h0);
        check("rst IF_ID_Instr", IF_ID_Instr, NOP);
        @(posedge clk); #1; rst_n = 1;

        // Sequential fetch, 1-cycle memory.
        cycle(1, 1, 0, 0, 0, 0);
        check("seq req0", 32'(imem_req), 32'd1);
        check("seq addr0", imem_addr, 32'h0);
        cycle(1, 1, 0, 0, 1, 32'h2001_0005);
        check("seq idle1", 32'(imem_req), 32'd0);
        cycle(1, 1, 0, 0, 0, 0);
        check("seq addr4", imem_addr, 32'h4);
        check("seq ifid pc0", IF_ID_PC, 32'h0);
        check("seq ifid instr0", IF_ID_Instr, 32'h2001_0005);
        check("seq ifid v0", 32'(IF_ID_Valid), 32'd1);
        cycle(1, 1, 0, 0, 1, 32'h2002_0007);
        cycle(1, 1, 0, 0, 0, 0);
        check("seq ifid pc4", IF_ID_PC, 32'h4);
        check("seq ifid instr4", IF_ID_Instr, 32'h2002_0007);
        check("seq addr8", imem_addr, 32'h8);

        // Stall with response in flight -> parked, then released.
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 32'hAAAA_0008);
        cycle(0, 0, 0, 0, 0, 0);
        check("stall no req", 32'(imem_req), 32'd0);
        check("stall ifid v", 32'(IF_ID_Valid), 32'd0);
        check("stall ifid pc", IF_ID_PC, 32'h4);
        cycle(1, 1, 0, 0, 0, 0);
        check("full no req", 32'(imem_req), 32'd0);
        cycle(1, 1, 0, 0, 0, 0);
        check("held pc", IF_ID_PC, 32'h8);
        check("held instr", IF_ID_Instr, 32'hAAAA_0008);
        check("resume addr", imem_addr, 32'hC);

        // Branch while waiting (latency 3): stale response killed.
        cycle(1, 1, 1, 32'h100, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 1, 32'hDEAD_BEEF);
        cycle(1, 1, 0, 0, 0, 0);
        check("kill ifid v", 32'(IF_ID_Valid), 32'd0);
        check("kill next addr", imem_addr, 32'h100);
        cycle(1, 1, 0, 0, 1, 32'h1111_0100);

        // Branch in S_REQ: same-cycle bypass.
        cycle(1, 1, 1, 32'h40, 0, 0);
        check("bypass req", 32'(imem_req), 32'd1);
        check("bypass addr", imem_addr, 32'h40);
        cycle(1, 1, 0, 0, 1, 32'h2222_0040);
        check("bypass flush v", 32'(IF_ID_Valid), 32'd0);

        // Branch with PCWrite=0 ignored.
        cycle(0, 0, 1, 32'h200, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        check("nobr ifid pc", IF_ID_PC, 32'h40);
        check("nobr ifid v", 32'(IF_ID_Valid), 32'd1);
        check("nobr addr", imem_addr, 32'h44);
        cycle(1, 1, 0, 0, 1, 32'h3333_0044);
        cycle(1, 1, 0, 0, 0, 0);
        check("pre-rst addr", imem_addr, 32'h48);

        // Reset while waiting; late response after release must be dropped.
        @(negedge clk);
        rst_n = 0;
        model_reset();
        #1;
        check("mid rst req", 32'(imem_req), 32'd0);
        check("mid rst v", 32'(IF_ID_Valid), 32'd0);
        @(posedge clk); #1; rst_n = 1;
        cycle(0, 1, 0, 0, 0, 0);
        check("post rst no req", 32'(imem_req), 32'd0);
        cycle(0, 1, 0, 0, 1, 32'hBAD0_BAD0);
        cycle(1, 1, 0, 0, 0, 0);
        check("post rst addr", imem_addr, 32'h0);
        check("post rst ifid v", 32'(IF_ID_Valid), 32'd0);
        cycle(1, 1, 0, 0, 1, 32'h4444_0000);
        cycle(1, 1, 0, 0, 0, 0);
        check("post rst instr", IF_ID_Instr, 32'h4444_0000);
        mem_busy = imem_req;
        mem_due  = int'($urandom_range(0, 3));

        // Randomized traffic with variable latency and spurious strobes.
        for (int c = 0; c < 4000; c++) begin
            v = 0;
            if (mem_busy && c == mem_due) begin
                v = 1; mem_busy = 0;
            end else if (!mem_busy && $urandom_range(0, 9) == 0) begin
                v = 1;
            end
            r = $urandom;
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : {r[31:2], 2'b00};
            cycle($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) == 0, tgt, v, $urandom);
            if (imem_req) begin
                mem_busy = 1;
                mem_due  = c + int'($urandom_range(1, 4));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
